// File: rtl/rv_enc_pkg.sv
// Shared RV32I encoding constants, request opcodes, FSM states and pack types.
package rv_enc_pkg;

  // Major opcodes (shared with the immediate decoder)
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  // req_op codes; 9..15 are illegal
  localparam logic [3:0] OP_OPIMM  = 4'd0;
  localparam logic [3:0] OP_LOAD   = 4'd1;
  localparam logic [3:0] OP_STORE  = 4'd2;
  localparam logic [3:0] OP_LUI    = 4'd3;
  localparam logic [3:0] OP_AUIPC  = 4'd4;
  localparam logic [3:0] OP_BRANCH = 4'd5;
  localparam logic [3:0] OP_JAL    = 4'd6;
  localparam logic [3:0] OP_JALR   = 4'd7;
  localparam logic [3:0] OP_LI     = 4'd8;

  localparam logic [31:0] INST_NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_HI   = 2'd2
  } state_e;

  typedef struct packed {
    logic [3:0]  op;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
  } pack_req_t;

  typedef struct packed {
    logic [31:0] inst;
    logic        err;
  } pack_rsp_t;

endpackage

// File: rtl/inst_pack.sv
// Combinational field packer: one machine-level op + immediate -> RV32I word and range flag.
module inst_pack
  import rv_enc_pkg::*;
#(
  parameter bit CHK_RANGE = 1'b1
) (
  input  pack_req_t req,
  output pack_rsp_t rsp
);

  logic [31:0] imm;
  logic        i_ok, b_ok, j_ok, u_ok;

  assign imm = req.imm;

  // Representable when the bits above the field are a pure sign extension
  assign i_ok = (&imm[31:11]) | ~(|imm[31:11]);
  assign b_ok = ((&imm[31:12]) | ~(|imm[31:12])) & ~imm[0];
  assign j_ok = ((&imm[31:20]) | ~(|imm[31:20])) & ~imm[0];
  assign u_ok = ~(|imm[11:0]);

  // Bit scatter per format; out-of-range immediates are emitted truncated
  always_comb begin
    rsp.inst = INST_NOP;
    rsp.err  = 1'b1;
    case (req.op)
      OP_OPIMM: begin
        rsp.inst = {imm[11:0], req.rs1, req.funct3, req.rd, OPC_OPIMM};
        rsp.err  = ~i_ok;
      end
      OP_LOAD: begin
        rsp.inst = {imm[11:0], req.rs1, req.funct3, req.rd, OPC_LOAD};
        rsp.err  = ~i_ok;
      end
      OP_JALR: begin
        rsp.inst = {imm[11:0], req.rs1, 3'b000, req.rd, OPC_JALR};
        rsp.err  = ~i_ok;
      end
      OP_STORE: begin
        rsp.inst = {imm[11:5], req.rs2, req.rs1, req.funct3, imm[4:0], OPC_STORE};
        rsp.err  = ~i_ok;
      end
      OP_BRANCH: begin
        rsp.inst = {imm[12], imm[10:5], req.rs2, req.rs1, req.funct3,
                    imm[4:1], imm[11], OPC_BRANCH};
        rsp.err  = ~b_ok;
      end
      OP_JAL: begin
        rsp.inst = {imm[20], imm[10:1], imm[11], imm[19:12], req.rd, OPC_JAL};
        rsp.err  = ~j_ok;
      end
      OP_LUI: begin
        rsp.inst = {imm[31:12], req.rd, OPC_LUI};
        rsp.err  = ~u_ok;
      end
      OP_AUIPC: begin
        rsp.inst = {imm[31:12], req.rd, OPC_AUIPC};
        rsp.err  = ~u_ok;
      end
      default: begin
        // LI is split by the parent; anything reaching here is illegal -> NOP
        rsp.inst = INST_NOP;
        rsp.err  = 1'b1;
      end
    endcase
    if (!CHK_RANGE) rsp.err = 1'b0;
  end

endmodule

// File: rtl/inst_enc.sv
// Instruction encoder: valid/ready request in, one registered word stream out.
// LI expands into LUI (+ ADDI when the low part is non-zero).
module inst_enc
  import rv_enc_pkg::*;
#(
  parameter bit CHK_RANGE = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_op,
  input  logic [2:0]  req_funct3,
  input  logic [4:0]  req_rd,
  input  logic [4:0]  req_rs1,
  input  logic [4:0]  req_rs2,
  input  logic [31:0] req_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic        out_last,
  output logic        out_err
);

  state_e      state, state_nxt;
  logic        accept;
  logic [31:0] li_sum;
  logic [11:0] li_lo;
  logic        li_small, li_two;
  pack_req_t   first_req, addi_req;
  pack_rsp_t   first_rsp, addi_rsp;
  logic [31:0] pend_inst;
  logic        pend_err;

  assign req_ready = (state == ST_IDLE) | ((state == ST_HOLD) & out_ready);
  assign accept    = req_valid & req_ready;
  assign out_valid = (state != ST_IDLE);

  // LI split: hi is rounded so that sign-extended lo adds back to imm
  assign li_sum   = req_imm + 32'h0000_0800;
  assign li_lo    = req_imm[11:0];
  assign li_small = (&req_imm[31:11]) | ~(|req_imm[31:11]);
  assign li_two   = (req_op == OP_LI) & ~li_small & (|li_lo);

  // First word request: LI becomes ADDI rd,x0 or LUI rd; other ops pass through
  always_comb begin
    first_req = '{op: req_op, funct3: req_funct3, rd: req_rd, rs1: req_rs1,
                  rs2: req_rs2, imm: req_imm};
    if (req_op == OP_LI) begin
      if (li_small)
        first_req = '{op: OP_OPIMM, funct3: 3'b000, rd: req_rd, rs1: 5'd0,
                      rs2: 5'd0, imm: req_imm};
      else
        first_req = '{op: OP_LUI, funct3: 3'b000, rd: req_rd, rs1: 5'd0,
                      rs2: 5'd0, imm: {li_sum[31:12], 12'h000}};
    end
  end

  // Second word of a two-word LI: ADDI rd,rd,lo
  assign addi_req = '{op: OP_OPIMM, funct3: 3'b000, rd: req_rd, rs1: req_rd,
                      rs2: 5'd0, imm: {{20{li_lo[11]}}, li_lo}};

  inst_pack #(.CHK_RANGE(CHK_RANGE)) u_pack_first (.req(first_req), .rsp(first_rsp));
  inst_pack #(.CHK_RANGE(CHK_RANGE)) u_pack_addi  (.req(addi_req),  .rsp(addi_rsp));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next state: accept, drain, or advance from the LUI to the pending ADDI
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept) state_nxt = li_two ? ST_HI : ST_HOLD;
      ST_HOLD: if (out_ready) state_nxt = accept ? (li_two ? ST_HI : ST_HOLD) : ST_IDLE;
      ST_HI:   if (out_ready) state_nxt = ST_HOLD;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Output and pending-ADDI registers; untouched while stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_inst  <= 32'h0;
      out_last  <= 1'b0;
      out_err   <= 1'b0;
      pend_inst <= 32'h0;
      pend_err  <= 1'b0;
    end else if (accept) begin
      out_inst  <= first_rsp.inst;
      out_last  <= ~li_two;
      out_err   <= first_rsp.err;
      pend_inst <= addi_rsp.inst;
      pend_err  <= addi_rsp.err;
    end else if ((state == ST_HI) && out_ready) begin
      out_inst  <= pend_inst;
      out_last  <= 1'b1;
      out_err   <= pend_err;
    end
  end

endmodule

// File: tb/tb_inst_enc.sv
// Randomized scoreboard bench for inst_enc with a field-level reference model.
module tb_inst_enc;

  typedef struct packed {
    logic [31:0] inst;
    logic        last;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [3:0]  req_op = '0;
  logic [2:0]  req_funct3 = '0;
  logic [4:0]  req_rd = '0, req_rs1 = '0, req_rs2 = '0;
  logic [31:0] req_imm = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_inst;
  logic        out_last, out_err;

  int   n_vec = 0, n_err = 0, cyc = 0;
  int   rdy_mode = 1;           // 0 random, 1 always ready, 2 never ready
  exp_t sb[$];
  exp_t pend_exp[$];
  int   pop_cyc[$];
  logic prev_stall = 1'b0;
  exp_t prev_word;

  inst_enc #(.CHK_RANGE(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_funct3(req_funct3), .req_rd(req_rd),
    .req_rs1(req_rs1), .req_rs2(req_rs2), .req_imm(req_imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_inst(out_inst), .out_last(out_last), .out_err(out_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Consumer readiness, driven shortly after each rising edge
  initial forever begin
    @(posedge clk); #2;
    out_ready = (rdy_mode == 0) ? ($urandom_range(0, 1) == 1) : (rdy_mode == 1);
  end

  // ---------------- reference model ----------------
  function automatic bit fits(input logic [31:0] v, input int n);
    longint s, lim;
    s   = longint'($signed(v));
    lim = 64'sd1 <<< (n - 1);
    return (s >= -lim) && (s < lim);
  endfunction

  function automatic logic [31:0] w_i(input logic [31:0] opc, f3, rd, rs1, imm);
    return ((imm & 32'hFFF) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | opc;
  endfunction
  function automatic logic [31:0] w_s(input logic [31:0] opc, f3, rs1, rs2, imm);
    return (((imm >> 5) & 32'h7F) << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12)
         | ((imm & 32'h1F) << 7) | opc;
  endfunction
  function automatic logic [31:0] w_b(input logic [31:0] f3, rs1, rs2, imm);
    return (((imm >> 12) & 32'h1) << 31) | (((imm >> 5) & 32'h3F) << 25) | (rs2 << 20)
         | (rs1 << 15) | (f3 << 12) | (((imm >> 1) & 32'hF) << 8)
         | (((imm >> 11) & 32'h1) << 7) | 32'h63;
  endfunction
  function automatic logic [31:0] w_j(input logic [31:0] rd, imm);
    return (((imm >> 20) & 32'h1) << 31) | (((imm >> 1) & 32'h3FF) << 21)
         | (((imm >> 11) & 32'h1) << 20) | (((imm >> 12) & 32'hFF) << 12)
         | (rd << 7) | 32'h6F;
  endfunction
  function automatic logic [31:0] w_u(input logic [31:0] opc, rd, imm);
    return (imm & 32'hFFFF_F000) | (rd << 7) | opc;
  endfunction

  task automatic expect_word(input logic [31:0] inst, input bit last, input bit err);
    exp_t e;
    e.inst = inst; e.last = last; e.err = err;
    pend_exp.push_back(e);
  endtask

  task automatic model(input logic [3:0] op, input logic [2:0] f3,
                       input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [31:0] imm);
    logic [31:0] hi, lo, f, d, s1, s2;
    f = 32'(f3); d = 32'(rd); s1 = 32'(rs1); s2 = 32'(rs2);
    case (op)
      4'd0: expect_word(w_i(32'h13, f, d, s1, imm), 1, !fits(imm, 12));
      4'd1: expect_word(w_i(32'h03, f, d, s1, imm), 1, !fits(imm, 12));
      4'd2: expect_word(w_s(32'h23, f, s1, s2, imm), 1, !fits(imm, 12));
      4'd3: expect_word(w_u(32'h37, d, imm), 1, (imm % 4096) != 0);
      4'd4: expect_word(w_u(32'h17, d, imm), 1, (imm % 4096) != 0);
      4'd5: expect_word(w_b(f, s1, s2, imm), 1, !fits(imm, 13) || imm[0]);
      4'd6: expect_word(w_j(d, imm), 1, !fits(imm, 21) || imm[0]);
      4'd7: expect_word(w_i(32'h67, 0, d, s1, imm), 1, !fits(imm, 12));
      4'd8: begin
        if (fits(imm, 12)) expect_word(w_i(32'h13, 0, d, 0, imm), 1, 0);
        else begin
          hi = (imm + 32'd2048) >> 12;
          lo = imm & 32'hFFF;
          expect_word(w_u(32'h37, d, hi << 12), lo == 0, 0);
          if (lo != 0) expect_word(w_i(32'h13, 0, d, d, lo), 1, 0);
        end
      end
      default: expect_word(32'h0000_0013, 1, 1);
    endcase
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic [3:0] op, input logic [2:0] f3,
                       input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [31:0] imm);
    int w;
    req_op = op; req_funct3 = f3; req_rd = rd; req_rs1 = rs1; req_rs2 = rs2;
    req_imm = imm; req_valid = 1'b1;
    w = 0;
    @(negedge clk);
    while (!req_ready && w < 200) begin w++; @(negedge clk); end
    if (!req_ready) begin
      n_vec++; n_err++;
      $display("FAIL accept_timeout: req_ready=%0b required 1 (op=%0d)", req_ready, op);
      pend_exp.delete();
    end else begin
      while (pend_exp.size() != 0) sb.push_back(pend_exp.pop_front());
    end
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [3:0] op, input logic [2:0] f3,
                      input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [31:0] imm);
    model(op, f3, rd, rs1, rs2, imm);
    drive(op, f3, rd, rs1, rs2, imm);
  endtask

  task automatic idle();
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int w;
    idle();
    w = 0;
    while (sb.size() != 0 && w < 500) begin @(negedge clk); #1; w++; end
    if (sb.size() != 0) begin
      n_vec++; n_err++;
      $display("FAIL drain_timeout: %0d words outstanding, required 0", sb.size());
      sb.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    exp_t e, cur;
    cur.inst = out_inst; cur.last = out_last; cur.err = out_err;
    if (!rst_n) prev_stall = 1'b0;
    else begin
      if (prev_stall && out_valid) begin
        n_vec++;
        if (cur !== prev_word) begin
          n_err++;
          $display("FAIL stall_hold: got %h/%b/%b required %h/%b/%b", cur.inst, cur.last,
                   cur.err, prev_word.inst, prev_word.last, prev_word.err);
        end
      end
      if (out_valid && out_ready) begin
        pop_cyc.push_back(cyc);
        n_vec++;
        if (sb.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_word: got %h last=%b err=%b required none",
                   out_inst, out_last, out_err);
        end else begin
          e = sb.pop_front();
          if (cur !== e) begin
            n_err++;
            $display("FAIL word: got %h last=%b err=%b required %h last=%b err=%b",
                     cur.inst, cur.last, cur.err, e.inst, e.last, e.err);
          end
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_word  = cur;
    end
  end

  // ---------------- stimulus ----------------
  function automatic logic [31:0] rand_imm();
    case ($urandom_range(0, 5))
      0: return 32'($urandom_range(0, 4095)) - 32'd2048;
      1: return 32'($urandom_range(0, 63)) - 32'd32 + (($urandom_range(0, 1) == 1) ? 32'd2048 : -32'd2048);
      2: return $urandom() & 32'hFFFF_F000;
      3: return (32'($urandom_range(0, 2097151)) - 32'd1048576) & ~32'h1;
      4: return 32'($urandom_range(0, 8191)) - 32'd4096;
      default: return $urandom();
    endcase
  endfunction

  initial begin
    // reset state
    #3;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_inst",  out_inst, 32'd0);
    check("rst_out_last",  32'(out_last), 32'd0);
    check("rst_out_err",   32'(out_err), 32'd0);
    @(posedge clk); #1; rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_req_ready", 32'(req_ready), 32'd1);

    // directed vectors with constant expectations
    rdy_mode = 1;
    expect_word(32'hFFF0_0293, 1, 0);
    drive(4'd0, 3'd0, 5'd5, 5'd0, 5'd0, 32'hFFFF_FFFF);
    check("latency_valid", 32'(out_valid), 32'd1);
    idle(); drain();
    expect_word(32'h1234_5537, 0, 0); expect_word(32'h6785_0513, 1, 0);
    drive(4'd8, 3'd0, 5'd10, 5'd0, 5'd0, 32'h1234_5678); drain();
    expect_word(32'h0000_10B7, 0, 0); expect_word(32'h8000_8093, 1, 0);
    drive(4'd8, 3'd0, 5'd1, 5'd0, 5'd0, 32'h0000_0800); drain();
    expect_word(32'h1234_5537, 1, 0);
    drive(4'd8, 3'd0, 5'd10, 5'd0, 5'd0, 32'h1234_5000); drain();
    expect_word(32'h0080_00EF, 1, 0);
    drive(4'd6, 3'd0, 5'd1, 5'd0, 5'd0, 32'd8); drain();
    expect_word(32'h0000_0163, 1, 1);
    drive(4'd5, 3'd0, 5'd0, 5'd0, 5'd0, 32'd3); drain();
    expect_word(32'h0000_0013, 1, 1);
    drive(4'd0, 3'd0, 5'd0, 5'd0, 5'd0, 32'd4096); drain();
    expect_word(32'h0000_0013, 1, 1);
    drive(4'd9, 3'd5, 5'd3, 5'd4, 5'd5, 32'h55); drain();

    // backpressure during LI: LUI held, no new accept
    rdy_mode = 2;
    expect_word(32'h1234_5537, 0, 0); expect_word(32'h6785_0513, 1, 0);
    drive(4'd8, 3'd0, 5'd10, 5'd0, 5'd0, 32'h1234_5678);
    idle();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_inst", out_inst, 32'h1234_5537);
      check("bp_req_ready", 32'(req_ready), 32'd0);
    end
    rdy_mode = 1;
    @(posedge clk); #1;
    drain();

    // reset mid-LI: pending ADDI is dropped
    rdy_mode = 2;
    model(4'd8, 3'd0, 5'd10, 5'd0, 5'd0, 32'h1234_5678);
    drive(4'd8, 3'd0, 5'd10, 5'd0, 5'd0, 32'h1234_5678);
    idle();
    @(negedge clk); #2;
    rst_n = 1'b0; sb.delete();
    #1;
    check("rst_mid_valid", 32'(out_valid), 32'd0);
    check("rst_mid_ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1; rst_n = 1'b1; rdy_mode = 1;
    repeat (6) @(posedge clk);
    #1;
    check("post_rst_valid", 32'(out_valid), 32'd0);

    // back-to-back: 8 single-word requests on consecutive cycles
    pop_cyc.delete();
    for (int i = 0; i < 8; i++)
      send(4'd0, 3'($urandom_range(0, 7)), 5'($urandom), 5'($urandom), 5'd0,
           32'($urandom_range(0, 4095)) - 32'd2048);
    drain();
    check("b2b_count", 32'(pop_cyc.size()), 32'd8);
    if (pop_cyc.size() == 8) check("b2b_span", 32'(pop_cyc[7] - pop_cyc[0]), 32'd7);

    // randomized traffic with random backpressure and gaps
    rdy_mode = 0;
    for (int i = 0; i < 300; i++) begin
      logic [3:0] op;
      op = ($urandom_range(0, 3) == 0) ? 4'd8 : 4'($urandom_range(0, 15));
      send(op, 3'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), rand_imm());
      if ($urandom_range(0, 4) == 0) begin
        idle();
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end
    rdy_mode = 1;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1);
  end

endmodule
